// File: rtl/tlc_conflict_monitor_if.sv
// tlc_conflict_monitor_if: lamp/walk samples toward the monitor, fault status back
interface tlc_conflict_monitor_if;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk_ns;
   logic       walk_ew;
   logic       fault_clr;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash_out;
   logic [7:0] fault_count;
   modport master (
      output ns_light, ew_light, walk_ns, walk_ew, fault_clr,
      input  fault, fault_code, flash_out, fault_count
   );
   modport slave (
      input  ns_light, ew_light, walk_ns, walk_ew, fault_clr,
      output fault, fault_code, flash_out, fault_count
   );
endinterface

// File: rtl/tlc_conflict_monitor.sv
// tlc_conflict_monitor: latches the first lamp/walk rule violation and drives flash until a verified all-red clear
module tlc_conflict_monitor #(
   parameter int MIN_YELLOW_TIME   = 30,
   parameter int MIN_ALL_RED_TIME  = 5,
   parameter int FLASH_HALF_PERIOD = 16,
   parameter int CNT_W             = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   tlc_conflict_monitor_if.slave mon
);
   localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
   typedef enum logic [1:0] {MONITOR = 2'd0, FAULT = 2'd1, CLEARING = 2'd2} state_t;
   state_t           state_q, state_d;
   logic [2:0]       code_q, code_d, prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
   logic [7:0]       count_q, count_d;
   logic             flash_q, flash_d;
   logic [CNT_W-1:0] yel_ns_q, yel_ns_d, yel_ew_q, yel_ew_d, allred_q, allred_d;
   logic [CNT_W-1:0] qual_q, qual_d, fcnt_q, fcnt_d;
   logic [2:0]       ns, ew, viol;
   logic             bad_enc, conflict, bad_seq, short_yel, short_clr, bad_walk;
   logic             all_red, clr_ok, flash_tick;
   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction
   function automatic logic seq_bad(input logic [2:0] p, input logic [2:0] c);
      return (p == G && c == R) || (p == R && c == Y) || (p == Y && c == G);
   endfunction
   assign ns         = mon.ns_light;
   assign ew         = mon.ew_light;
   assign bad_enc    = !$onehot(ns) || !$onehot(ew);
   assign conflict   = ns != R && ew != R;
   assign bad_seq    = seq_bad(prev_ns_q, ns) || seq_bad(prev_ew_q, ew);
   assign short_yel  = (prev_ns_q == Y && ns == R && yel_ns_q < CNT_W'(MIN_YELLOW_TIME)) ||
                       (prev_ew_q == Y && ew == R && yel_ew_q < CNT_W'(MIN_YELLOW_TIME));
   assign short_clr  = ((prev_ns_q == R && ns == G) || (prev_ew_q == R && ew == G)) &&
                       allred_q < CNT_W'(MIN_ALL_RED_TIME);
   assign bad_walk   = (mon.walk_ns && ns != G) || (mon.walk_ew && ew != G);
   assign viol       = bad_enc ? 3'd1 : conflict ? 3'd2 : bad_seq ? 3'd3 :
                       short_yel ? 3'd4 : short_clr ? 3'd5 : bad_walk ? 3'd6 : 3'd0;
   assign all_red    = ns == R && ew == R;
   assign clr_ok     = all_red && !mon.walk_ns && !mon.walk_ew;
   assign flash_tick = fcnt_q == CNT_W'(FLASH_HALF_PERIOD - 1);
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      count_d   = count_q;
      prev_ns_d = prev_ns_q;
      prev_ew_d = prev_ew_q;
      yel_ns_d  = yel_ns_q;
      yel_ew_d  = yel_ew_q;
      allred_d  = allred_q;
      qual_d    = qual_q;
      flash_d   = flash_tick ? !flash_q : flash_q;
      fcnt_d    = flash_tick ? '0 : fcnt_q + CNT_W'(1);
      case (state_q)
         MONITOR: begin
            prev_ns_d = ns;
            prev_ew_d = ew;
            yel_ns_d  = ns == Y ? inc(yel_ns_q) : '0;
            yel_ew_d  = ew == Y ? inc(yel_ew_q) : '0;
            allred_d  = all_red ? inc(allred_q) : '0;
            fcnt_d    = '0;
            flash_d   = viol != 3'd0;
            if (viol != 3'd0) begin
               state_d = FAULT;
               code_d  = viol;
               count_d = (&count_q) ? count_q : count_q + 8'd1;
            end
         end
         FAULT: begin
            if (mon.fault_clr) begin
               state_d = CLEARING;
               qual_d  = '0;
            end
         end
         CLEARING: begin
            qual_d = clr_ok ? qual_q + CNT_W'(1) : '0;
            if (!clr_ok) state_d = FAULT;
            else if (qual_q == CNT_W'(MIN_ALL_RED_TIME - 1)) begin
               // Exit with a full all-red credit so the next green is not flagged.
               state_d   = MONITOR;
               code_d    = 3'd0;
               flash_d   = 1'b0;
               fcnt_d    = '0;
               prev_ns_d = R;
               prev_ew_d = R;
               yel_ns_d  = '0;
               yel_ew_d  = '0;
               allred_d  = CNT_W'(MIN_ALL_RED_TIME);
               qual_d    = '0;
            end
         end
         default: begin
            state_d = FAULT;
            code_d  = 3'd7;
            flash_d = 1'b1;
            fcnt_d  = '0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= MONITOR;
         code_q    <= 3'd0;
         count_q   <= 8'd0;
         flash_q   <= 1'b0;
         prev_ns_q <= R;
         prev_ew_q <= R;
         yel_ns_q  <= '0;
         yel_ew_q  <= '0;
         allred_q  <= '0;
         qual_q    <= '0;
         fcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         count_q   <= count_d;
         flash_q   <= flash_d;
         prev_ns_q <= prev_ns_d;
         prev_ew_q <= prev_ew_d;
         yel_ns_q  <= yel_ns_d;
         yel_ew_q  <= yel_ew_d;
         allred_q  <= allred_d;
         qual_q    <= qual_d;
         fcnt_q    <= fcnt_d;
      end
   end
   assign mon.fault       = state_q != MONITOR;
   assign mon.fault_code  = code_q;
   assign mon.flash_out   = flash_q;
   assign mon.fault_count = count_q;
endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// tb_tlc_conflict_monitor: segment table with scoreboard plus hand-written flash sequence
module tb_tlc_conflict_monitor;
   localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   tlc_conflict_monitor_if bus();
   tlc_conflict_monitor dut (.clk(clk), .rst_n(rst_n), .mon(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic       r;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       wns;
      logic       wew;
      logic       clr;
      int         n;
      logic       ef;
      logic [2:0] ec;
      logic [7:0] ecnt;
   } vec_t;
   typedef struct {
      int         id;
      logic       ef;
      logic [2:0] ec;
      logic [7:0] ecnt;
   } exp_t;
   vec_t vecs[$];
   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;
   task automatic add(input logic r, input logic [2:0] ns, input logic [2:0] ew, input logic wns,
                      input logic wew, input logic clr, input int n, input logic ef,
                      input logic [2:0] ec, input logic [7:0] ecnt);
      vec_t v;
      v.r = r; v.ns = ns; v.ew = ew; v.wns = wns; v.wew = wew; v.clr = clr; v.n = n;
      v.ef = ef; v.ec = ec; v.ecnt = ecnt;
      vecs.push_back(v);
   endtask
   task automatic step(input logic r, input logic [2:0] ns, input logic [2:0] ew, input logic wns,
                       input logic wew, input logic clr, input int n);
      rst_n         = !r;
      bus.ns_light  = ns;
      bus.ew_light  = ew;
      bus.walk_ns   = wns;
      bus.walk_ew   = wew;
      bus.fault_clr = clr;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
      end
   endtask
   initial begin
      exp_t e;
      bus.ns_light = R; bus.ew_light = R; bus.walk_ns = 1'b0; bus.walk_ew = 1'b0; bus.fault_clr = 1'b0;
      // legal cycles, then a conflict during EW green
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         add(0, R, G, 0, 0, 0, 301, 0, 0, 0);
         add(0, R, Y, 0, 0, 0, 31, 0, 0, 0);
         add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
         add(0, G, R, 0, 0, 0, 121, 0, 0, 0);
         add(0, Y, R, 0, 0, 0, 31, 0, 0, 0);
         add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      end
      add(0, R, G, 0, 0, 0, 10, 0, 0, 0);
      add(0, G, G, 0, 0, 0, 1, 1, 2, 1);
      // short yellow 29 faults, 30 is legal
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      add(0, R, G, 0, 0, 0, 5, 0, 0, 0);
      add(0, R, Y, 0, 0, 0, 29, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 1, 1, 4, 1);
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      add(0, R, G, 0, 0, 0, 5, 0, 0, 0);
      add(0, R, Y, 0, 0, 0, 30, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 1, 0, 0, 0);
      // encoding beats walk
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      add(0, 3'b110, R, 1, 0, 0, 1, 1, 1, 1);
      // walk on a red approach
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      add(0, G, R, 0, 0, 0, 3, 0, 0, 0);
      add(0, G, R, 0, 1, 0, 1, 1, 6, 1);
      // G->R, clear, green right after clear, second fault, aborted clear, held-clr clear
      add(1, R, R, 0, 0, 0, 2, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 6, 0, 0, 0);
      add(0, G, R, 0, 0, 0, 3, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 1, 1, 3, 1);
      add(0, R, R, 0, 0, 1, 1, 1, 3, 1);
      add(0, R, R, 0, 0, 0, 4, 1, 3, 1);
      add(0, R, R, 0, 0, 0, 1, 0, 0, 1);
      add(0, G, R, 0, 0, 0, 1, 0, 0, 1);
      add(0, R, R, 0, 0, 0, 1, 1, 3, 2);
      add(0, R, R, 0, 0, 1, 1, 1, 3, 2);
      add(0, R, R, 0, 0, 0, 2, 1, 3, 2);
      add(0, Y, R, 0, 0, 0, 1, 1, 3, 2);
      add(0, R, R, 0, 0, 0, 5, 1, 3, 2);
      add(0, R, R, 0, 0, 1, 1, 1, 3, 2);
      add(0, R, R, 0, 0, 1, 5, 0, 0, 2);
      // clr coinciding with fault entry is ignored
      add(0, R, R, 0, 0, 0, 6, 0, 0, 2);
      add(0, G, G, 0, 0, 1, 1, 1, 2, 3);
      add(0, R, R, 0, 0, 0, 5, 1, 2, 3);
      // reset during clearing, then a too-early first green
      add(0, R, R, 0, 0, 1, 1, 1, 2, 3);
      add(0, R, R, 0, 0, 0, 2, 1, 2, 3);
      add(1, R, R, 0, 0, 0, 1, 0, 0, 0);
      add(0, R, R, 0, 0, 0, 4, 0, 0, 0);
      add(0, G, R, 0, 0, 0, 1, 1, 5, 1);
      foreach (vecs[i]) begin
         sb.push_back('{id: i, ef: vecs[i].ef, ec: vecs[i].ec, ecnt: vecs[i].ecnt});
         step(vecs[i].r, vecs[i].ns, vecs[i].ew, vecs[i].wns, vecs[i].wew, vecs[i].clr, vecs[i].n);
         e = sb.pop_front();
         chk("fault", e.id, 32'(bus.fault), 32'(e.ef));
         chk("fault_code", e.id, 32'(bus.fault_code), 32'(e.ec));
         chk("fault_count", e.id, 32'(bus.fault_count), 32'(e.ecnt));
      end
      // flash timing around a conflict fault
      step(1, R, R, 0, 0, 0, 2);
      chk("flash_rst", 0, 32'(bus.flash_out), 0);
      step(0, R, R, 0, 0, 0, 6);
      chk("flash_mon", 1, 32'(bus.flash_out), 0);
      step(0, G, G, 0, 0, 0, 1);
      chk("flash_entry", 2, 32'(bus.flash_out), 1);
      chk("code_entry", 2, 32'(bus.fault_code), 2);
      step(0, G, G, 0, 0, 0, 15);
      chk("flash_e15", 3, 32'(bus.flash_out), 1);
      step(0, G, G, 0, 0, 0, 1);
      chk("flash_e16", 4, 32'(bus.flash_out), 0);
      step(0, G, G, 0, 0, 0, 15);
      chk("flash_e31", 5, 32'(bus.flash_out), 0);
      step(0, G, G, 0, 0, 0, 1);
      chk("flash_e32", 6, 32'(bus.flash_out), 1);
      step(0, R, R, 0, 0, 1, 1);
      step(0, R, R, 0, 0, 0, 5);
      chk("flash_clr", 7, 32'(bus.flash_out), 0);
      chk("fault_clr", 7, 32'(bus.fault), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
- Independent safety monitor on the receiving end of the traffic light controller's lamp and walk outputs.
- Samples ns_light, ew_light, walk_ns and walk_ew every clock and checks them against the one-hot encoding, conflict, sequence and timing rules.
- On the first violation it latches a fault code, asserts fault and drives a flash output for the cabinet's flash-transfer relay.
- Exit from fault requires a clear request followed by a verified all-red interval.

Parameters:
- MIN_YELLOW_TIME, 'd30: minimum consecutive yellow samples before a yellow-to-red transition is legal.
- MIN_ALL_RED_TIME, 'd5: minimum consecutive both-red samples before any red-to-green transition. Also the clear-qualification interval.
- FLASH_HALF_PERIOD, 'd16: cycles per flash_out half period.
- CNT_W, 16: width of the dwell counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ns_light  in  3  NS lamp state: 100 green, 010 yellow, 001 red.
- ew_light  in  3  EW lamp state, same encoding as ns_light.
- walk_ns  in  1  NS walk indication.
- walk_ew  in  1  EW walk indication.
- fault_clr  in  1  clear request, level-sampled, honoured only in FAULT.
- fault  out  1  high in FAULT and CLEARING.
- fault_code  out  3  latched code of the first violation; 0 = none.
- flash_out  out  1  flash drive, toggling while fault is high.
- fault_count  out  8  number of MONITOR-to-FAULT entries, saturating at 255.

Behaviour:
- Reset (rst_n low at posedge):
  - state = MONITOR; fault = 0, fault_code = 0, flash_out = 0, fault_count = 0.
  - Previous-sample registers are set to RED for both approaches.
  - All dwell counters are set to 0, flash counter to 0.
  - Reset asserted mid-fault clears everything, including a latched code.
- Tracking in MONITOR:
  - prev_ns and prev_ew hold the previous cycle's samples.
  - yel_cnt_x counts consecutive prior samples with approach x yellow. It resets to 0 on any sample that is not yellow.
  - allred_cnt counts consecutive prior samples with both approaches red.
  - All counters saturate at all-ones.
- Violation codes, evaluated on the current sample; lowest code wins when several fire in the same cycle:
  - 1 ENCODING: either light is not exactly one-hot.
  - 2 CONFLICT: both lights are non-red.
  - 3 SEQUENCE: a transition G->R, R->Y or Y->G on either approach. Unchanged colour is legal.
  - 4 SHORT_YELLOW: Y->R with yel_cnt of that approach < MIN_YELLOW_TIME.
  - 5 SHORT_CLEAR: R->G on either approach with allred_cnt < MIN_ALL_RED_TIME. This includes the first green after reset.
  - 6 WALK: walk_ns high while ns_light != 100, or walk_ew high while ew_light != 100.
- Latency: a violation sampled at edge N gives fault = 1 and the valid fault_code after edge N (visible in cycle N+1). fault_count increments at the same edge.
- States:
  - MONITOR -> FAULT on any violation.
  - FAULT: fault_code is frozen and no further checks run. FAULT -> CLEARING when fault_clr = 1.
  - CLEARING: a qualification counter counts consecutive samples with both lights = 001 and both walks = 0.
    - Any other sample resets the counter and returns to FAULT with the code unchanged.
    - When the counter reaches MIN_ALL_RED_TIME: go to MONITOR, fault_code = 0, fault = 0, and set allred_cnt = MIN_ALL_RED_TIME so the next green is legal. prev registers = RED, yel_cnt = 0.
  - Unreachable state encodings -> FAULT with code 7.
- Flash:
  - On entering FAULT the flash counter is 0 and flash_out = 1.
  - flash_out toggles every FLASH_HALF_PERIOD cycles while in FAULT or CLEARING.
  - flash_out is forced to 0 in MONITOR.
- Simultaneous events:
  - fault_clr in the same cycle as the FAULT entry is ignored.
  - fault_clr held in CLEARING has no effect.

Test Plan:
- Legal cycle: reset, 6 all-red, EW green 301, EW yellow 31, all-red 6, NS green 121, NS yellow 31, repeat twice -> fault stays 0, fault_code 0, fault_count 0.
- Conflict: drive ns=100, ew=100 for one cycle during an EW green -> next cycle fault = 1, fault_code = 2, flash_out = 1, toggling every 16 cycles.
- Short yellow: EW yellow held for 29 cycles then red -> fault_code = 4. Repeat with 30 cycles -> no fault.
- Priority: apply ns=110 with walk_ns=1 -> fault_code = 1, not 6. Apply G->R directly -> fault_code = 3.
- Clear:
  - From FAULT, pulse fault_clr, then 5 all-red samples -> MONITOR, fault_code = 0, fault_count = 1.
  - Repeat with a yellow at sample 3 -> back to FAULT, code retained.
- Reset: rst_n low during CLEARING -> all outputs 0. A first green after only 4 all-red samples -> fault_code = 5.
